// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch port, the data port and the shared single-port RAM bus of unified_mem_arbiter.
// The arbiter takes the slave view; the pipeline/RAM environment takes the master view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;
  logic              busy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_q,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port and the data port.
// Data has priority; a saturating streak counter forces fetch through after MAX_D_STREAK data wins.
module unified_mem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 2
) (
  input logic                 clk,
  input logic                 rst,
  unified_mem_arbiter_if.slave bus
);
  localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE = 2'd0, I_WAIT = 2'd1, D_WAIT = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              fetch_wins;
  logic              i_gnt, d_gnt, i_rvalid, d_rvalid, mem_we, busy;
  logic [DATA_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  // Arbitration, next-state and all outputs; reset forces every output to zero.
  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    fetch_wins = 1'b0;
    i_gnt      = 1'b0;
    d_gnt      = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    i_rdata    = '0;
    d_rdata    = '0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b0;
    if (rst) begin
      state_d  = IDLE;
      streak_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          fetch_wins = bus.i_req && (!bus.d_req || (streak_q == STREAK_MAX));
          if (fetch_wins) begin
            i_gnt    = 1'b1;
            mem_addr = bus.i_addr;
            state_d  = I_WAIT;
            streak_d = '0;
          end else if (bus.d_req) begin
            d_gnt    = 1'b1;
            mem_addr = bus.d_addr;
            if (bus.d_we) begin
              mem_we    = 1'b1;
              mem_wdata = bus.d_wdata;
              state_d   = IDLE;
            end else begin
              state_d = D_WAIT;
            end
            // Only wins taken while fetch is waiting count towards starvation.
            if (bus.i_req) begin
              if (streak_q != STREAK_MAX) begin
                streak_d = streak_q + SW'(1);
              end else begin
                streak_d = streak_q;
              end
            end else begin
              streak_d = '0;
            end
          end else begin
            state_d = IDLE;
          end
        end
        I_WAIT: begin
          busy     = 1'b1;
          i_rvalid = 1'b1;
          i_rdata  = bus.mem_q;
          state_d  = IDLE;
        end
        D_WAIT: begin
          busy     = 1'b1;
          d_rvalid = 1'b1;
          d_rdata  = bus.mem_q;
          state_d  = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and streak registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
    end
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.i_rvalid  = i_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.i_rdata   = i_rdata;
  assign bus.d_rdata   = d_rdata;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.busy      = busy;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: transaction-level model (pending read + shadow memory) checked every
// cycle, directed scenarios with literal expectations, then protocol-respecting random traffic.
module tb_unified_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int MAXS = 2;

  logic clk;
  logic rst;
  unified_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  unified_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM environment: registered address, combinational read data, write at the clock edge.
  logic [DW-1:0] ram [256];
  logic [AW-1:0] ram_addr_r;
  assign bus.mem_q = ram[ram_addr_r];
  initial begin
    for (int k = 0; k < 256; k++) ram[k] = 32'(k + 1);
    ram_addr_r = '0;
    forever begin
      @(posedge clk);
      if (bus.mem_we === 1'b1) ram[bus.mem_addr] = bus.mem_wdata;
      ram_addr_r = bus.mem_addr;
    end
  end

  // Model state and observation logs.
  logic [DW-1:0] shadow [256];
  bit            pend_v;
  bit            pend_d;
  logic [DW-1:0] pend_data;
  int            streak;
  bit            m_i_gnt, m_d_gnt;
  int            cyc;
  byte           gnt_log[$];
  int            gnt_cyc[$];
  logic [DW-1:0] ird_log[$];
  logic [DW-1:0] drd_log[$];
  int            we_cnt;

  // Every-cycle comparison of all DUT outputs against the transaction model.
  initial begin
    bit            e_ig, e_dg, e_iv, e_dv, e_we, e_busy;
    logic [DW-1:0] e_ird, e_drd, e_wd;
    logic [AW-1:0] e_addr;
    for (int k = 0; k < 256; k++) shadow[k] = 32'(k + 1);
    pend_v = 1'b0; pend_d = 1'b0; pend_data = '0; streak = 0; cyc = 0; we_cnt = 0;
    m_i_gnt = 1'b0; m_d_gnt = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      e_ig = 1'b0; e_dg = 1'b0; e_iv = 1'b0; e_dv = 1'b0; e_we = 1'b0; e_busy = 1'b0;
      e_ird = '0; e_drd = '0; e_wd = '0; e_addr = '0;
      if (rst) begin
        pend_v = 1'b0;
        streak = 0;
      end else if (pend_v) begin
        e_busy = 1'b1;
        if (pend_d) begin e_dv = 1'b1; e_drd = pend_data; end
        else begin e_iv = 1'b1; e_ird = pend_data; end
        pend_v = 1'b0;
      end else if (bus.i_req && (!bus.d_req || streak == MAXS)) begin
        e_ig = 1'b1; e_addr = bus.i_addr;
        pend_v = 1'b1; pend_d = 1'b0; pend_data = shadow[bus.i_addr];
        streak = 0;
      end else if (bus.d_req) begin
        e_dg = 1'b1; e_addr = bus.d_addr;
        if (bus.d_we) begin
          e_we = 1'b1; e_wd = bus.d_wdata; shadow[bus.d_addr] = bus.d_wdata;
        end else begin
          pend_v = 1'b1; pend_d = 1'b1; pend_data = shadow[bus.d_addr];
        end
        streak = bus.i_req ? ((streak + 1 > MAXS) ? MAXS : streak + 1) : 0;
      end
      m_i_gnt = e_ig;
      m_d_gnt = e_dg;
      check_val("i_gnt", 32'(bus.i_gnt), 32'(e_ig));
      check_val("d_gnt", 32'(bus.d_gnt), 32'(e_dg));
      check_val("i_rvalid", 32'(bus.i_rvalid), 32'(e_iv));
      check_val("d_rvalid", 32'(bus.d_rvalid), 32'(e_dv));
      check_val("i_rdata", bus.i_rdata, e_ird);
      check_val("d_rdata", bus.d_rdata, e_drd);
      check_val("mem_we", 32'(bus.mem_we), 32'(e_we));
      check_val("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      check_val("mem_wdata", bus.mem_wdata, e_wd);
      check_val("busy", 32'(bus.busy), 32'(e_busy));
      if (bus.i_gnt === 1'b1) begin gnt_log.push_back("I"); gnt_cyc.push_back(cyc); end
      if (bus.d_gnt === 1'b1) begin gnt_log.push_back("D"); gnt_cyc.push_back(cyc); end
      if (bus.i_rvalid === 1'b1) ird_log.push_back(bus.i_rdata);
      if (bus.d_rvalid === 1'b1) drd_log.push_back(bus.d_rdata);
      if (bus.mem_we === 1'b1) we_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    gnt_log.delete(); gnt_cyc.delete(); ird_log.delete(); drd_log.delete(); we_cnt = 0;
  endtask

  // Waits (bounded) until the model reports a grant on the chosen port in the current cycle.
  task automatic wait_gnt(input bit is_d);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 20) begin
      sample();
      got = is_d ? m_d_gnt : m_i_gnt;
      n++;
    end
    check_val(is_d ? "d_gnt_timeout" : "i_gnt_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    string exp_order;
    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    sample();
    check_val("reset_busy", 32'(bus.busy), 32'd0);
    check_val("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
    step();
    rst = 1'b0;

    // Fetch stream over addresses 0..3.
    clear_logs();
    bus.i_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.i_addr = 8'(k);
      wait_gnt(1'b0);
      step();
    end
    bus.i_req = 1'b0;
    repeat (3) step();
    check_val("t1_rdata_count", 32'(ird_log.size()), 32'd4);
    if (ird_log.size() == 4) begin
      for (int k = 0; k < 4; k++) check_val("t1_rdata", ird_log[k], 32'(k + 1));
      for (int k = 1; k < 4; k++) check_val("t1_gnt_spacing", 32'(gnt_cyc[k] - gnt_cyc[k-1]), 32'd2);
    end

    // Store 8 to address 29, then load it back immediately.
    clear_logs();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'd29; bus.d_wdata = 32'd8;
    wait_gnt(1'b1);
    step();
    bus.d_we = 1'b0; bus.d_wdata = '0;
    wait_gnt(1'b1);
    step();
    bus.d_req = 1'b0;
    repeat (2) step();
    check_val("t2_we_cycles", 32'(we_cnt), 32'd1);
    check_val("t2_load_count", 32'(drd_log.size()), 32'd1);
    if (drd_log.size() == 1) check_val("t2_load_data", drd_log[0], 32'd8);
    if (gnt_cyc.size() == 2) check_val("t2_gnt_spacing", 32'(gnt_cyc[1] - gnt_cyc[0]), 32'd1);

    // Contention: both ports request continuously for 12 cycles.
    clear_logs();
    bus.i_req = 1'b1; bus.i_addr = 8'd10;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'd11;
    repeat (12) @(posedge clk);
    #1;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (3) step();
    exp_order = "DDIDDI";
    check_val("t3_gnt_count", 32'(gnt_log.size()), 32'd6);
    if (gnt_log.size() == 6) begin
      for (int k = 0; k < 6; k++) check_val("t3_gnt_order", 32'(gnt_log[k]), 32'(exp_order[k]));
    end

    // Data request rising during a fetch wait.
    bus.i_req = 1'b1; bus.i_addr = 8'd5;
    wait_gnt(1'b0);
    step();
    bus.i_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'd6;
    sample();
    check_val("t4_no_gnt_in_wait", 32'(bus.d_gnt), 32'd0);
    check_val("t4_busy", 32'(bus.busy), 32'd1);
    check_val("t4_i_rdata", bus.i_rdata, 32'd6);
    step();
    sample();
    check_val("t4_gnt_after_wait", 32'(bus.d_gnt), 32'd1);
    step();
    bus.d_req = 1'b0;
    sample();
    check_val("t4_d_rdata", bus.d_rdata, 32'd7);
    step();

    // Reset while a load is outstanding.
    bus.d_req = 1'b1; bus.d_addr = 8'd3;
    wait_gnt(1'b1);
    step();
    rst = 1'b1; bus.d_req = 1'b0;
    sample();
    check_val("t5_rvalid_dropped", 32'(bus.d_rvalid), 32'd0);
    check_val("t5_busy", 32'(bus.busy), 32'd0);
    check_val("t5_mem_we", 32'(bus.mem_we), 32'd0);
    step();
    rst = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 8'd0;
    wait_gnt(1'b0);
    step();
    bus.i_req = 1'b0;
    sample();
    check_val("t5_i_rvalid", 32'(bus.i_rvalid), 32'd1);
    check_val("t5_i_rdata", bus.i_rdata, 32'd1);
    step();

    // Fetch request pulsed only during a data wait is cancelled.
    bus.d_req = 1'b1; bus.d_addr = 8'd4;
    wait_gnt(1'b1);
    step();
    clear_logs();
    bus.d_req = 1'b0; bus.i_req = 1'b1; bus.i_addr = 8'd7;
    step();
    bus.i_req = 1'b0;
    repeat (4) step();
    check_val("t6_no_fetch_gnt", 32'(gnt_log.size()), 32'd0);
    check_val("t6_no_i_rvalid", 32'(ird_log.size()), 32'd0);

    // Random traffic that respects the hold-until-grant protocol.
    for (int c = 0; c < 500; c++) begin
      step();
      rst = ($urandom_range(0, 99) == 0);
      if (bus.i_req && !m_i_gnt) begin
        if ($urandom_range(0, 19) == 0) bus.i_req = 1'b0;
      end else begin
        bus.i_req  = 1'($urandom_range(0, 1));
        bus.i_addr = 8'($urandom_range(0, 31));
      end
      if (bus.d_req && !m_d_gnt) begin
        if ($urandom_range(0, 19) == 0) bus.d_req = 1'b0;
      end else begin
        bus.d_req   = 1'($urandom_range(0, 1));
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = 8'($urandom_range(0, 31));
        bus.d_wdata = $urandom;
      end
    end
    step();
    rst = 1'b0; bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
